// File: rtl/dt_postproc.sv
`default_nettype none
// ============================================================================
//  Module   : dt_postproc
//  Purpose  : Scans a 128x128 distance map once, producing a thresholded,
//             16-pixel-packed mask plus max value/location and foreground count.
//  Revision : 1.0  initial release
// ============================================================================
module dt_postproc (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [7:0]  threshold,
   output logic        res_rd,
   output logic [13:0] res_addr,
   input  logic [7:0]  res_di,
   output logic        out_wr,
   output logic [9:0]  out_addr,
   output logic [15:0] out_do,
   output logic [7:0]  max_val,
   output logic [13:0] max_addr,
   output logic [14:0] fg_count,
   output logic        busy,
   output logic        done
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_READ  = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   localparam logic [13:0] C_LAST_ADDR = 14'd16383;

   state_t      r_state;
   state_t      w_next;
   logic [13:0] r_addr;
   logic [7:0]  r_thr;
   logic        r_pix_vld;
   logic [13:0] r_pix_idx;
   logic [15:0] r_pack;
   logic        r_out_wr;
   logic [9:0]  r_out_addr;
   logic [15:0] r_out_do;
   logic [7:0]  r_max_val;
   logic [13:0] r_max_addr;
   logic [14:0] r_fg_count;
   logic        w_start_acc;
   logic [15:0] w_pack_nxt;

   assign w_start_acc = (r_state == S_IDLE) && start;
   assign w_pack_nxt  = {r_pack[14:0], (res_di >= r_thr)};

   assign res_addr = r_addr;
   assign out_wr   = r_out_wr;
   assign out_addr = r_out_addr;
   assign out_do   = r_out_do;
   assign max_val  = r_max_val;
   assign max_addr = r_max_addr;
   assign fg_count = r_fg_count;

   always_ff @(posedge clk) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      res_rd = 1'b0;
      busy   = 1'b1;
      done   = 1'b0;
      case (r_state)
         S_IDLE: begin
            busy = 1'b0;
            if (start) w_next = S_READ;
         end
         S_READ: begin
            res_rd = 1'b1;
            if (r_addr == C_LAST_ADDR) w_next = S_DRAIN;
         end
         // The only write that can land in DRAIN is the final word.
         S_DRAIN: begin
            if (r_out_wr) w_next = S_DONE;
         end
         S_DONE: begin
            done   = 1'b1;
            w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_addr     <= '0;
         r_thr      <= '0;
         r_pix_vld  <= 1'b0;
         r_pix_idx  <= '0;
         r_pack     <= '0;
         r_out_wr   <= 1'b0;
         r_out_addr <= '0;
         r_out_do   <= '0;
         r_max_val  <= '0;
         r_max_addr <= '0;
         r_fg_count <= '0;
      end else begin
         // Read data returns one cycle after its address, so track that address.
         r_pix_vld <= (r_state == S_READ);
         r_pix_idx <= r_addr;
         r_out_wr  <= 1'b0;
         if (w_start_acc) begin
            r_thr      <= threshold;
            r_addr     <= '0;
            r_pack     <= '0;
            r_max_val  <= '0;
            r_max_addr <= '0;
            r_fg_count <= '0;
         end else begin
            if (r_state == S_READ && r_addr != C_LAST_ADDR)
               r_addr <= r_addr + 14'd1;
            if (r_pix_vld) begin
               r_pack <= w_pack_nxt;
               if (res_di > r_max_val) begin
                  r_max_val  <= res_di;
                  r_max_addr <= r_pix_idx;
               end
               if (res_di != 8'd0)
                  r_fg_count <= r_fg_count + 15'd1;
               if (r_pix_idx[3:0] == 4'hF) begin
                  r_out_wr   <= 1'b1;
                  r_out_do   <= w_pack_nxt;
                  r_out_addr <= r_pix_idx[13:4];
               end
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_dt_postproc.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dt_postproc
//  Purpose  : Directed scoreboard bench for dt_postproc.
//  Revision : 1.0  initial release
// ============================================================================
module tb_dt_postproc;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [7:0]  threshold;
   logic        res_rd;
   logic [13:0] res_addr;
   logic [7:0]  res_di;
   logic        out_wr;
   logic [9:0]  out_addr;
   logic [15:0] out_do;
   logic [7:0]  max_val;
   logic [13:0] max_addr;
   logic [14:0] fg_count;
   logic        busy;
   logic        done;

   dt_postproc dut (
      .clk(clk), .reset(reset), .start(start), .threshold(threshold),
      .res_rd(res_rd), .res_addr(res_addr), .res_di(res_di),
      .out_wr(out_wr), .out_addr(out_addr), .out_do(out_do),
      .max_val(max_val), .max_addr(max_addr), .fg_count(fg_count),
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   logic [7:0] mem [0:16383];
   always @(posedge clk) if (res_rd) res_di <= mem[res_addr];

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int addr;
      int data;
      int cyc;
   } wr_t;

   wr_t wq[$];
   int  dq[$];
   wr_t e_wr;
   int  e_done;
   int  n_cmp = 0;
   int  n_bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: consumes expected writes and done pulses as the DUT presents them.
   always @(negedge clk) begin
      if (out_wr === 1'b1) begin
         if (wq.size() == 0) chk("unexpected_write", 1, 0);
         else begin
            e_wr = wq.pop_front();
            chk("wr_addr", 32'(out_addr), e_wr.addr);
            chk("wr_data", 32'(out_do), e_wr.data);
            chk("wr_cycle", cyc, e_wr.cyc);
         end
      end
      if (done === 1'b1) begin
         if (dq.size() == 0) chk("unexpected_done", 1, 0);
         else begin
            e_done = dq.pop_front();
            chk("done_cycle", cyc, e_done);
         end
      end
   end

   task automatic fill(input logic [7:0] v);
      for (int i = 0; i < 16384; i++) mem[i] = v;
   endtask

   task automatic push_exp(input int s, input logic [15:0] dflt, input int ow, input logic [15:0] ov);
      wr_t w;
      for (int i = 0; i < 1024; i++) begin
         w.addr = i;
         w.data = (i == ow) ? int'(ov) : int'(dflt);
         w.cyc  = s + 18 + 16 * i;
         wq.push_back(w);
      end
      dq.push_back(s + 16387);
   endtask

   task automatic start_job(input logic [7:0] thr, output int s);
      @(negedge clk);
      start     = 1'b1;
      threshold = thr;
      s         = cyc;
      @(negedge clk);
      start     = 1'b0;
      threshold = ~thr;
      chk("busy_first", busy, 1);
   endtask

   task automatic finish_job(input int s, input logic [7:0] mv, input int ma, input int fg, input bit restart);
      while (cyc < s + 16389) begin
         @(negedge clk);
         start = (restart && cyc == s + 100);
         if (start) threshold = 8'd0;
         if (cyc == s + 16387) chk("busy_last", busy, 1);
         if (cyc == s + 16388) begin
            chk("busy_after", busy, 0);
            chk("done_width", done, 0);
         end
      end
      start = 1'b0;
      chk("writes_left", wq.size(), 0);
      chk("done_left", dq.size(), 0);
      chk("max_val", 32'(max_val), 32'(mv));
      chk("max_addr", 32'(max_addr), ma);
      chk("fg_count", 32'(fg_count), fg);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_res_rd"}, res_rd, 0);
      chk({tag, "_out_wr"}, out_wr, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_res_addr"}, 32'(res_addr), 0);
      chk({tag, "_out_addr"}, 32'(out_addr), 0);
      chk({tag, "_out_do"}, 32'(out_do), 0);
      chk({tag, "_max_val"}, 32'(max_val), 0);
      chk({tag, "_max_addr"}, 32'(max_addr), 0);
      chk({tag, "_fg_count"}, 32'(fg_count), 0);
   endtask

   int s;

   initial begin
      reset = 1'b1; start = 1'b0; threshold = 8'd0;
      fill(8'd0);
      repeat (3) @(negedge clk);
      chk_all_zero("reset");
      reset = 1'b0;

      // Reset wins over a simultaneous start.
      @(negedge clk); reset = 1'b1; start = 1'b1;
      @(negedge clk); reset = 1'b0; start = 1'b0;
      chk("rst_start_busy", busy, 0);
      @(negedge clk);
      chk("rst_start_busy2", busy, 0);
      chk("rst_start_rd", res_rd, 0);

      // All-zero map, threshold 1.
      fill(8'd0);
      start_job(8'd1, s);
      push_exp(s, 16'h0000, -1, 16'h0000);
      finish_job(s, 8'd0, 0, 0, 1'b0);

      // Sparse map with a tie on the max, plus an ignored mid-run start.
      fill(8'd0);
      mem[130] = 8'd5; mem[131] = 8'd5; mem[200] = 8'd3;
      start_job(8'd4, s);
      push_exp(s, 16'h0000, 8, 16'h3000);
      finish_job(s, 8'd5, 130, 3, 1'b1);

      // All ones, threshold 0.
      fill(8'd1);
      start_job(8'd0, s);
      push_exp(s, 16'hFFFF, -1, 16'h0000);
      finish_job(s, 8'd1, 0, 16384, 1'b0);

      // Reset in the middle of a scan.
      fill(8'd0);
      mem[130] = 8'd5; mem[131] = 8'd5; mem[200] = 8'd3;
      start_job(8'd4, s);
      push_exp(s, 16'h0000, 8, 16'h3000);
      while (cyc < s + 5000) @(negedge clk);
      reset = 1'b1;
      wq.delete();
      dq.delete();
      @(negedge clk);
      reset = 1'b0;
      chk_all_zero("midreset");
      @(negedge clk);
      chk("midreset_idle", busy, 0);

      // Single max pixel at the very last address, threshold 255.
      fill(8'd0);
      mem[16383] = 8'd255;
      start_job(8'd255, s);
      push_exp(s, 16'h0000, 1023, 16'h0001);
      finish_job(s, 8'd255, 16383, 1, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
